// File: rtl/gate_sensor_decoder_pkg.sv
// rtl/gate_sensor_decoder_pkg.sv - shared state and beam-code definitions for the gate sensor decoder
package gate_sensor_decoder_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ENT1,
        ST_ENT2,
        ST_ENT3,
        ST_EXT1,
        ST_EXT2,
        ST_EXT3,
        ST_WAIT_CLR,
        ST_FAULT
    } state_e;

    // Beam codes are {outer, inner}, 1 = blocked
    localparam logic [1:0] CODE_CLR  = 2'b00;
    localparam logic [1:0] CODE_OUT  = 2'b10;
    localparam logic [1:0] CODE_IN   = 2'b01;
    localparam logic [1:0] CODE_BOTH = 2'b11;

    function automatic logic is_timed(input state_e s);
        return (s != ST_IDLE) && (s != ST_FAULT);
    endfunction

endpackage

// File: rtl/gate_sensor_decoder_if.sv
// rtl/gate_sensor_decoder_if.sv - sensor inputs and event outputs of the gate sensor decoder
interface gate_sensor_decoder_if;
    logic       beam_outer;
    logic       beam_inner;
    logic [1:0] switch;
    logic       entry_pulse;
    logic       exit_pulse;
    logic [1:0] slot_id;
    logic       busy;
    logic       fault;

    modport master (
        output beam_outer, beam_inner, switch,
        input  entry_pulse, exit_pulse, slot_id, busy, fault
    );

    modport slave (
        input  beam_outer, beam_inner, switch,
        output entry_pulse, exit_pulse, slot_id, busy, fault
    );
endinterface

// File: rtl/gate_sensor_decoder_beam_debouncer.sv
// rtl/gate_sensor_decoder_beam_debouncer.sv - 2-FF synchroniser plus stable-count debounce for one beam
module gate_sensor_decoder_beam_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4_000_000,
    parameter int CNT_W           = 29
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        // Any cycle agreeing with the accepted level restarts the stability count
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
endmodule

// File: rtl/gate_sensor_decoder.sv
// rtl/gate_sensor_decoder.sv - decodes debounced gate beams into tagged entry/exit events
module gate_sensor_decoder #(
    parameter int DEBOUNCE_CYCLES = 4_000_000,
    parameter int TIMEOUT_CYCLES  = 400_000_000,
    parameter int CNT_W           = 29
) (
    input  logic                 clk,
    input  logic                 reset,
    gate_sensor_decoder_if.slave bus
);
    import gate_sensor_decoder_pkg::*;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             outer_lvl, inner_lvl;
    logic [1:0]       code;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [1:0]       sw_sync1_q, sw_sync1_d;
    logic [1:0]       sw_sync2_q, sw_sync2_d;
    logic [1:0]       slot_hold_q, slot_hold_d;
    logic [1:0]       slot_id_q, slot_id_d;
    logic             entry_pulse_q, entry_pulse_d;
    logic             exit_pulse_q, exit_pulse_d;

    gate_sensor_decoder_beam_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_outer (
        .clk(clk), .reset(reset), .raw(bus.beam_outer), .level(outer_lvl)
    );

    gate_sensor_decoder_beam_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_inner (
        .clk(clk), .reset(reset), .raw(bus.beam_inner), .level(inner_lvl)
    );

    assign code = {outer_lvl, inner_lvl};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: case (code)
                CODE_OUT:  state_d = ST_ENT1;
                CODE_IN:   state_d = ST_EXT1;
                CODE_BOTH: state_d = ST_WAIT_CLR;
                default:   state_d = ST_IDLE;
            endcase
            ST_ENT1: case (code)
                CODE_BOTH: state_d = ST_ENT2;
                CODE_CLR:  state_d = ST_IDLE;
                CODE_IN:   state_d = ST_WAIT_CLR;
                default:   state_d = ST_ENT1;
            endcase
            ST_ENT2: case (code)
                CODE_IN:   state_d = ST_ENT3;
                CODE_OUT:  state_d = ST_ENT1;
                CODE_CLR:  state_d = ST_IDLE;
                default:   state_d = ST_ENT2;
            endcase
            ST_ENT3: case (code)
                CODE_CLR:  state_d = ST_IDLE;
                CODE_BOTH: state_d = ST_ENT2;
                CODE_OUT:  state_d = ST_WAIT_CLR;
                default:   state_d = ST_ENT3;
            endcase
            ST_EXT1: case (code)
                CODE_BOTH: state_d = ST_EXT2;
                CODE_CLR:  state_d = ST_IDLE;
                CODE_OUT:  state_d = ST_WAIT_CLR;
                default:   state_d = ST_EXT1;
            endcase
            ST_EXT2: case (code)
                CODE_OUT:  state_d = ST_EXT3;
                CODE_IN:   state_d = ST_EXT1;
                CODE_CLR:  state_d = ST_IDLE;
                default:   state_d = ST_EXT2;
            endcase
            ST_EXT3: case (code)
                CODE_CLR:  state_d = ST_IDLE;
                CODE_BOTH: state_d = ST_EXT2;
                CODE_IN:   state_d = ST_WAIT_CLR;
                default:   state_d = ST_EXT3;
            endcase
            ST_WAIT_CLR, ST_FAULT: if (code == CODE_CLR) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Timeout wins over any beam transition in the same cycle
        if (is_timed(state_q) && (timer_q == TIMEOUT_LAST)) begin
            state_d = ST_FAULT;
        end

        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (is_timed(state_q) && (timer_q != TIMEOUT_LAST)) begin
            timer_d = timer_q + CNT_W'(1);
        end

        entry_pulse_d = (state_q == ST_ENT3) && (state_d == ST_IDLE);
        exit_pulse_d  = (state_q == ST_EXT3) && (state_d == ST_IDLE);

        sw_sync1_d = bus.switch;
        sw_sync2_d = sw_sync1_q;

        slot_hold_d = slot_hold_q;
        if ((state_q == ST_IDLE) && ((state_d == ST_ENT1) || (state_d == ST_EXT1))) begin
            slot_hold_d = sw_sync2_q;
        end

        slot_id_d = slot_id_q;
        if (entry_pulse_d || exit_pulse_d) begin
            slot_id_d = slot_hold_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            sw_sync1_q    <= '0;
            sw_sync2_q    <= '0;
            slot_hold_q   <= '0;
            slot_id_q     <= '0;
            entry_pulse_q <= 1'b0;
            exit_pulse_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            sw_sync1_q    <= sw_sync1_d;
            sw_sync2_q    <= sw_sync2_d;
            slot_hold_q   <= slot_hold_d;
            slot_id_q     <= slot_id_d;
            entry_pulse_q <= entry_pulse_d;
            exit_pulse_q  <= exit_pulse_d;
        end
    end

    assign bus.entry_pulse = entry_pulse_q;
    assign bus.exit_pulse  = exit_pulse_q;
    assign bus.slot_id     = slot_id_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.fault       = (state_q == ST_FAULT);
endmodule

// File: tb/tb_gate_sensor_decoder.sv
// tb/tb_gate_sensor_decoder.sv - directed scoreboard bench for gate_sensor_decoder
module tb_gate_sensor_decoder;

    typedef struct packed {
        logic       is_exit;
        logic [1:0] slot;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    gate_sensor_decoder_if bus ();

    gate_sensor_decoder #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (64),
        .CNT_W          (29)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a beam code and watch every cycle for pulses against the scoreboard
    task automatic hold(input logic [1:0] code, input int n);
        exp_t e;
        bus.beam_outer = code[1];
        bus.beam_inner = code[0];
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (bus.entry_pulse || bus.exit_pulse) begin
                chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pulse_kind", 32'({bus.entry_pulse, bus.exit_pulse}),
                        e.is_exit ? 32'd1 : 32'd2);
                    chk("pulse_slot", 32'(bus.slot_id), 32'(e.slot));
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.beam_outer = 1'b0;
        bus.beam_inner = 1'b0;
        bus.switch = 2'b00;
        #1;
        chk("rst_entry", 32'(bus.entry_pulse), 32'd0);
        chk("rst_exit",  32'(bus.exit_pulse),  32'd0);
        chk("rst_slot",  32'(bus.slot_id),     32'd0);
        chk("rst_busy",  32'(bus.busy),        32'd0);
        chk("rst_fault", 32'(bus.fault),       32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1: entry with slot 2
        bus.switch = 2'b10;
        hold(2'b00, 5);
        hold(2'b10, 10);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        hold(2'b11, 10);
        hold(2'b01, 10);
        exp_q.push_back('{is_exit: 1'b0, slot: 2'd2});
        hold(2'b00, 10);
        chk("t1_drained", 32'(exp_q.size()), 32'd0);
        chk("t1_slot", 32'(bus.slot_id), 32'd2);
        chk("t1_idle", 32'(bus.busy), 32'd0);

        // 2: exit with slot 1; switch moves mid-transit
        bus.switch = 2'b01;
        hold(2'b00, 5);
        hold(2'b01, 10);
        bus.switch = 2'b11;
        hold(2'b11, 10);
        hold(2'b10, 10);
        exp_q.push_back('{is_exit: 1'b1, slot: 2'd1});
        hold(2'b00, 10);
        chk("t2_drained", 32'(exp_q.size()), 32'd0);
        chk("t2_slot", 32'(bus.slot_id), 32'd1);
        chk("t2_idle", 32'(bus.busy), 32'd0);

        // 3: outer bounces faster than the debounce window
        for (int r = 0; r < 6; r++) begin
            hold(2'b10, 3);
            hold(2'b00, 3);
            chk("t3_glitch_busy", 32'(bus.busy), 32'd0);
        end
        hold(2'b10, 10);
        chk("t3_busy", 32'(bus.busy), 32'd1);
        hold(2'b00, 10);
        chk("t3_idle", 32'(bus.busy), 32'd0);
        chk("t3_slot", 32'(bus.slot_id), 32'd1);

        // 4: car backs out, then an inconsistent pattern parks in WAIT_CLR
        hold(2'b10, 10);
        hold(2'b11, 10);
        hold(2'b10, 10);
        hold(2'b00, 10);
        chk("t4_backout_idle", 32'(bus.busy), 32'd0);
        hold(2'b10, 10);
        hold(2'b01, 10);
        chk("t4_waitclr_busy", 32'(bus.busy), 32'd1);
        hold(2'b00, 10);
        chk("t4_idle", 32'(bus.busy), 32'd0);
        chk("t4_drained", 32'(exp_q.size()), 32'd0);

        // 5: transit timeout
        hold(2'b11, 40);
        chk("t5_no_fault_yet", 32'(bus.fault), 32'd0);
        chk("t5_busy", 32'(bus.busy), 32'd1);
        hold(2'b11, 40);
        chk("t5_fault", 32'(bus.fault), 32'd1);
        hold(2'b00, 10);
        chk("t5_fault_clear", 32'(bus.fault), 32'd0);
        chk("t5_idle", 32'(bus.busy), 32'd0);

        // 6: reset while in ENT3
        bus.switch = 2'b11;
        hold(2'b00, 5);
        hold(2'b10, 10);
        hold(2'b11, 10);
        hold(2'b01, 10);
        chk("t6_busy", 32'(bus.busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_busy",  32'(bus.busy),        32'd0);
        chk("t6_rst_fault", 32'(bus.fault),       32'd0);
        chk("t6_rst_slot",  32'(bus.slot_id),     32'd0);
        chk("t6_rst_entry", 32'(bus.entry_pulse), 32'd0);
        chk("t6_rst_exit",  32'(bus.exit_pulse),  32'd0);
        bus.beam_outer = 1'b0;
        bus.beam_inner = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        hold(2'b00, 20);
        chk("t6_idle", 32'(bus.busy), 32'd0);
        chk("t6_slot", 32'(bus.slot_id), 32'd0);
        chk("t6_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
